rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE (32), datapath width.
REQ-002 Parameter ROB_ENTRY_WIDTH, default `ROB_ENTRY_WIDTH (3), entry-id width; depth N = 2**ROB_ENTRY_WIDTH.
REQ-003 Parameter REG_WIDTH, default 5, architectural register index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard all entries (misprediction/exception).
REQ-007 alloc_valid  input  1  decode requests an entry.
REQ-008 alloc_rd  input  REG_WIDTH  destination register of the allocating instruction.
REQ-009 alloc_we  input  1  allocating instruction writes alloc_rd.
REQ-010 alloc_ready  output  1  entry available (not full).
REQ-011 alloc_rob_id  output  ROB_ENTRY_WIDTH  id assigned on allocation (tail pointer).
REQ-012 {alu,mem,mul}_wb_enable  input  1 each  writeback strobe per unit.
REQ-013 {alu,mem,mul}_wb_rob_id  input  ROB_ENTRY_WIDTH each  target entry.
REQ-014 {alu,mem,mul}_wb_data  input  WORD_SIZE each  result value.
REQ-015 rs1_rob_entry, rs2_rob_entry  input  ROB_ENTRY_WIDTH each  read-port entry ids.
REQ-016 rob_s1_data, rob_s2_data  output  WORD_SIZE each  stored result of the addressed entry.
REQ-017 rob_s1_valid, rob_s2_valid  output  1 each  addressed entry allocated and result written.
REQ-018 commit_valid  output  1  head entry retires this cycle.
REQ-019 commit_rob_id, commit_rd, commit_we, commit_data  output  ROB_ENTRY_WIDTH/REG_WIDTH/1/WORD_SIZE  retiring entry id, destination, write enable, value.

Function
REQ-020 Per entry state: valid, ready, rd, we, data; pointers head, tail (ROB_ENTRY_WIDTH, wrap modulo N); count (ROB_ENTRY_WIDTH+1 bits, 0..N).
REQ-021 alloc_ready = (count != N), from registered count only; a commit in the same cycle does not free a slot for that cycle's allocation.
REQ-022 alloc_rob_id = tail, combinational.
REQ-023 Allocation when alloc_valid && alloc_ready: entry[tail] <= valid=1, ready=0, rd=alloc_rd, we=alloc_we, data=0; tail <= tail+1 (N-1 wraps to 0); alloc_valid while full is ignored.
REQ-024 Writeback: each enabled port whose target entry is valid sets ready=1 and data=wb_data next cycle; writeback to an invalid entry is ignored.
REQ-025 Two or more ports targeting the same id in one cycle is illegal; RTL resolves priority alu > mem > mul.
REQ-026 Read ports are combinational from registered state: rob_sX_valid = valid[id] && ready[id], rob_sX_data = data[id]; a same-cycle writeback is not visible (covered by the forwarding writeback bypasses).
REQ-027 commit_valid = valid[head] && ready[head] && !flush; commit_rob_id=head, commit_rd/we/data from entry[head], combinational.
REQ-028 On commit: valid[head] <= 0, head <= head+1 with wrap; at most one commit per cycle; the register file always accepts.
REQ-029 count next = count + alloc_fire - commit_fire; simultaneous allocate and commit leaves count unchanged.
REQ-030 Entries retire strictly in allocation order; a ready non-head entry waits for all older entries.
REQ-031 Entries with we=0 (stores, branches) commit with commit_we=0.
REQ-032 flush has priority over allocation, writeback and commit in the same cycle; next cycle all valid=0, head=tail=0, count=0.

Reset
REQ-033 rst asserted at a clock edge, including mid-operation, yields the flush state next cycle: all valid/ready=0, data=0, head=tail=count=0.
REQ-034 After reset: alloc_ready=1, alloc_rob_id=0, commit_valid=0, rob_s1_valid=rob_s2_valid=0, rob_s1_data=rob_s2_data=0; rst overrides flush and all inputs.

Verification
REQ-035 Allocate rd=5,7 (ids 0,1); mul writes id1=0x22, then alu id0=0x11 -> commit id0 (rd5,0x11) one cycle after the alu write, id1 (rd7,0x22) the next cycle.
REQ-036 Allocate 8 entries without writeback -> alloc_ready=0 after the 8th; 9th alloc_valid ignored; write+commit id0, same-cycle alloc rejected, accepted next cycle with alloc_rob_id=0 (wrap).
REQ-037 Entry 3 allocated; mem writes 0xABCD with rs1_rob_entry=3 -> rob_s1_valid=0 that cycle, 1 with data 0xABCD next cycle.
REQ-038 Same-cycle alu and mul writeback to id2 (0x1, 0x2) -> stored data 0x1.
REQ-039 Four entries in flight, head ready, flush asserted -> commit_valid=0 that cycle; next cycle alloc_rob_id=0, alloc_ready=1, all rob_sX_valid=0.
REQ-040 rst pulsed with 5 entries allocated and writebacks active -> all REQ-034 reset values next cycle; writeback to old ids afterward ignored.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: in-order retirement of out-of-order writebacks from three units.
// Entries are allocated at the tail, completed by writeback, and retired from the head.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif

module rob #(
    parameter int WORD_SIZE       = `WORD_SIZE,
    parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
    parameter int REG_WIDTH       = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [REG_WIDTH-1:0]       alloc_rd,
    input  logic                       alloc_we,
    output logic                       alloc_ready,
    output logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_id,
    input  logic                       alu_wb_enable,
    input  logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id,
    input  logic [WORD_SIZE-1:0]       alu_wb_data,
    input  logic                       mem_wb_enable,
    input  logic [ROB_ENTRY_WIDTH-1:0] mem_wb_rob_id,
    input  logic [WORD_SIZE-1:0]       mem_wb_data,
    input  logic                       mul_wb_enable,
    input  logic [ROB_ENTRY_WIDTH-1:0] mul_wb_rob_id,
    input  logic [WORD_SIZE-1:0]       mul_wb_data,
    input  logic [ROB_ENTRY_WIDTH-1:0] rs1_rob_entry,
    input  logic [ROB_ENTRY_WIDTH-1:0] rs2_rob_entry,
    output logic [WORD_SIZE-1:0]       rob_s1_data,
    output logic [WORD_SIZE-1:0]       rob_s2_data,
    output logic                       rob_s1_valid,
    output logic                       rob_s2_valid,
    output logic                       commit_valid,
    output logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
    output logic [REG_WIDTH-1:0]       commit_rd,
    output logic                       commit_we,
    output logic [WORD_SIZE-1:0]       commit_data
);

    localparam int N  = 2 ** ROB_ENTRY_WIDTH;
    localparam int CW = ROB_ENTRY_WIDTH + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(N);

    logic [ROB_ENTRY_WIDTH-1:0] head_reg;
    logic [ROB_ENTRY_WIDTH-1:0] tail_reg;
    logic [CW-1:0]              count_reg;

    logic [N-1:0]         valid_vec;
    logic [N-1:0]         ready_vec;
    logic [N-1:0]         we_vec;
    logic [REG_WIDTH-1:0] rd_vec   [N];
    logic [WORD_SIZE-1:0] data_vec [N];

    logic alloc_fire;
    logic commit_fire;

    // Fullness comes from the registered count only, so a same-cycle commit never frees a slot.
    assign alloc_ready  = (count_reg != FULL_COUNT);
    assign alloc_rob_id = tail_reg;
    assign alloc_fire   = alloc_valid && alloc_ready && !flush;

    assign commit_valid  = valid_vec[head_reg] && ready_vec[head_reg] && !flush;
    assign commit_fire   = commit_valid;
    assign commit_rob_id = head_reg;
    assign commit_rd     = rd_vec[head_reg];
    assign commit_we     = we_vec[head_reg];
    assign commit_data   = data_vec[head_reg];

    assign rob_s1_valid = valid_vec[rs1_rob_entry] && ready_vec[rs1_rob_entry];
    assign rob_s1_data  = data_vec[rs1_rob_entry];
    assign rob_s2_valid = valid_vec[rs2_rob_entry] && ready_vec[rs2_rob_entry];
    assign rob_s2_data  = data_vec[rs2_rob_entry];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (alloc_fire) begin
                tail_reg <= tail_reg + ROB_ENTRY_WIDTH'(1);
            end
            if (commit_fire) begin
                head_reg <= head_reg + ROB_ENTRY_WIDTH'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            localparam logic [ROB_ENTRY_WIDTH-1:0] ID = ROB_ENTRY_WIDTH'(gi);

            logic                 valid_reg;
            logic                 ready_reg;
            logic                 we_reg;
            logic [REG_WIDTH-1:0] rd_reg;
            logic [WORD_SIZE-1:0] data_reg;

            logic alloc_hit;
            logic commit_hit;
            logic alu_hit;
            logic mem_hit;
            logic mul_hit;

            assign alloc_hit  = alloc_fire && (tail_reg == ID);
            assign commit_hit = commit_fire && (head_reg == ID);
            // Writebacks only land on allocated entries; stale ids from before a flush fall away.
            assign alu_hit = alu_wb_enable && (alu_wb_rob_id == ID) && valid_reg;
            assign mem_hit = mem_wb_enable && (mem_wb_rob_id == ID) && valid_reg;
            assign mul_hit = mul_wb_enable && (mul_wb_rob_id == ID) && valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b0;
                    we_reg    <= 1'b0;
                    rd_reg    <= '0;
                    data_reg  <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b0;
                end else if (alloc_hit) begin
                    valid_reg <= 1'b1;
                    ready_reg <= 1'b0;
                    we_reg    <= alloc_we;
                    rd_reg    <= alloc_rd;
                    data_reg  <= '0;
                end else begin
                    if (commit_hit) begin
                        valid_reg <= 1'b0;
                    end
                    if (alu_hit) begin
                        ready_reg <= 1'b1;
                        data_reg  <= alu_wb_data;
                    end else if (mem_hit) begin
                        ready_reg <= 1'b1;
                        data_reg  <= mem_wb_data;
                    end else if (mul_hit) begin
                        ready_reg <= 1'b1;
                        data_reg  <= mul_wb_data;
                    end
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign ready_vec[gi] = ready_reg;
            assign we_vec[gi]    = we_reg;
            assign rd_vec[gi]    = rd_reg;
            assign data_vec[gi]  = data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus randomized traffic against
// a queue-based model of in-flight instructions.
module tb_rob;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic        alloc_we = 1'b0;
    logic        alloc_ready;
    logic [2:0]  alloc_rob_id;
    logic        alu_wb_enable = 1'b0;
    logic [2:0]  alu_wb_rob_id = '0;
    logic [31:0] alu_wb_data = '0;
    logic        mem_wb_enable = 1'b0;
    logic [2:0]  mem_wb_rob_id = '0;
    logic [31:0] mem_wb_data = '0;
    logic        mul_wb_enable = 1'b0;
    logic [2:0]  mul_wb_rob_id = '0;
    logic [31:0] mul_wb_data = '0;
    logic [2:0]  rs1_rob_entry = '0;
    logic [2:0]  rs2_rob_entry = '0;
    logic [31:0] rob_s1_data;
    logic [31:0] rob_s2_data;
    logic        rob_s1_valid;
    logic        rob_s2_valid;
    logic        commit_valid;
    logic [2:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic        commit_we;
    logic [31:0] commit_data;

    rob #(.WORD_SIZE(32), .ROB_ENTRY_WIDTH(3), .REG_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_we(alloc_we),
        .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
        .alu_wb_enable(alu_wb_enable), .alu_wb_rob_id(alu_wb_rob_id), .alu_wb_data(alu_wb_data),
        .mem_wb_enable(mem_wb_enable), .mem_wb_rob_id(mem_wb_rob_id), .mem_wb_data(mem_wb_data),
        .mul_wb_enable(mul_wb_enable), .mul_wb_rob_id(mul_wb_rob_id), .mul_wb_data(mul_wb_data),
        .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
        .rob_s1_data(rob_s1_data), .rob_s2_data(rob_s2_data),
        .rob_s1_valid(rob_s1_valid), .rob_s2_valid(rob_s2_valid),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
        .commit_we(commit_we), .commit_data(commit_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit started = 1'b0;

    // Model: in-flight instructions in program order, plus the last value stored per id.
    typedef struct {
        int          id;
        int          rd;
        bit          we;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          m_tail = 0;
    logic [31:0] m_data [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find(input int id);
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].id == id) return k;
        end
        return -1;
    endfunction

    task automatic apply_wb(input logic en, input logic [2:0] id, input logic [31:0] d);
        int k;
        k = find(int'(id));
        if (en && k >= 0) begin
            q[k].done = 1'b1;
            q[k].data = d;
            m_data[id] = d;
        end
    endtask

    always @(posedge clk) begin
        bit full;
        bit cfire;
        ent_t e;
        if (rst) begin
            q.delete();
            m_tail = 0;
            for (int k = 0; k < 8; k++) m_data[k] = '0;
        end else if (flush) begin
            q.delete();
            m_tail = 0;
        end else begin
            full  = (q.size() == 8);
            cfire = (q.size() > 0) && q[0].done;
            // Lowest priority first so alu's value is the one left standing.
            apply_wb(mul_wb_enable, mul_wb_rob_id, mul_wb_data);
            apply_wb(mem_wb_enable, mem_wb_rob_id, mem_wb_data);
            apply_wb(alu_wb_enable, alu_wb_rob_id, alu_wb_data);
            if (cfire) void'(q.pop_front());
            if (alloc_valid && !full) begin
                e.id = m_tail; e.rd = int'(alloc_rd); e.we = alloc_we; e.done = 1'b0; e.data = '0;
                q.push_back(e);
                m_data[m_tail] = '0;
                m_tail = (m_tail + 1) % 8;
            end
        end
    end

    always @(negedge clk) begin
        int  k1, k2;
        bit  exp_cv;
        if (started) begin
            chk("alloc_ready", alloc_ready, (q.size() != 8));
            chk("alloc_rob_id", alloc_rob_id, m_tail);
            exp_cv = (q.size() > 0) && q[0].done && !flush;
            chk("commit_valid", commit_valid, exp_cv);
            if (exp_cv) begin
                chk("commit_rob_id", commit_rob_id, q[0].id);
                chk("commit_rd", commit_rd, q[0].rd);
                chk("commit_we", commit_we, q[0].we);
                chk("commit_data", commit_data, q[0].data);
            end
            k1 = find(int'(rs1_rob_entry));
            k2 = find(int'(rs2_rob_entry));
            chk("rob_s1_valid", rob_s1_valid, (k1 >= 0) && q[k1].done);
            chk("rob_s2_valid", rob_s2_valid, (k2 >= 0) && q[k2].done);
            chk("rob_s1_data", rob_s1_data, m_data[rs1_rob_entry]);
            chk("rob_s2_data", rob_s2_data, m_data[rs2_rob_entry]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; alloc_rd = '0; alloc_we = 0;
        alu_wb_enable = 0; mem_wb_enable = 0; mul_wb_enable = 0;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1; alloc_rd = 5'(i + 1); alloc_we = 1;
            cyc();
        end
        alloc_valid = 0;
    endtask

    function automatic logic [2:0] pick_id();
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
            return 3'(q[$urandom_range(0, q.size() - 1)].id);
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        started = 1;
        #1;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_rob_id", alloc_rob_id, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_s1_valid", rob_s1_valid, 0);
        chk("rst_s1_data", rob_s1_data, 0);

        // In-order commit of out-of-order writebacks.
        alloc_valid = 1; alloc_rd = 5'd5; alloc_we = 1; cyc();
        alloc_rd = 5'd7; cyc();
        alloc_valid = 0;
        mul_wb_enable = 1; mul_wb_rob_id = 3'd1; mul_wb_data = 32'h22; cyc();
        mul_wb_enable = 0;
        chk("order_no_commit", commit_valid, 0);
        alu_wb_enable = 1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h11; cyc();
        alu_wb_enable = 0; #1;
        chk("commit0_valid", commit_valid, 1);
        chk("commit0_id", commit_rob_id, 0);
        chk("commit0_rd", commit_rd, 5);
        chk("commit0_data", commit_data, 32'h11);
        cyc();
        chk("commit1_valid", commit_valid, 1);
        chk("commit1_id", commit_rob_id, 1);
        chk("commit1_rd", commit_rd, 7);
        chk("commit1_data", commit_data, 32'h22);
        cyc();
        chk("drained", commit_valid, 0);

        // Fill, overflow attempt, commit with same-cycle alloc rejected, then wrap.
        reset_dut();
        alloc_n(8);
        #1;
        chk("full_ready", alloc_ready, 0);
        chk("full_tail", alloc_rob_id, 0);
        alloc_valid = 1; alloc_rd = 5'd30; cyc();
        chk("ninth_ignored", alloc_ready, 0);
        alu_wb_enable = 1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h99; cyc();
        alu_wb_enable = 0; #1;
        chk("full_commit_valid", commit_valid, 1);
        chk("full_commit_ready", alloc_ready, 0);
        cyc();
        chk("freed_ready", alloc_ready, 1);
        chk("freed_tail", alloc_rob_id, 0);
        cyc();
        chk("wrap_tail", alloc_rob_id, 1);
        chk("wrap_full", alloc_ready, 0);
        alloc_valid = 0;

        // Same-cycle writeback not visible on read port; visible next cycle.
        reset_dut();
        alloc_n(4);
        mem_wb_enable = 1; mem_wb_rob_id = 3'd3; mem_wb_data = 32'hABCD; rs1_rob_entry = 3'd3; #1;
        chk("bypass_s1_valid", rob_s1_valid, 0);
        cyc();
        mem_wb_enable = 0; #1;
        chk("read_s1_valid", rob_s1_valid, 1);
        chk("read_s1_data", rob_s1_data, 32'hABCD);

        // alu wins over mul on the same id.
        alu_wb_enable = 1; alu_wb_rob_id = 3'd2; alu_wb_data = 32'h1;
        mul_wb_enable = 1; mul_wb_rob_id = 3'd2; mul_wb_data = 32'h2;
        cyc();
        alu_wb_enable = 0; mul_wb_enable = 0; rs2_rob_entry = 3'd2; #1;
        chk("prio_data", rob_s2_data, 32'h1);
        chk("prio_valid", rob_s2_valid, 1);

        // Flush with ready head suppresses commit.
        alu_wb_enable = 1; alu_wb_rob_id = 3'd0; alu_wb_data = 32'h5; cyc();
        alu_wb_enable = 0; flush = 1; #1;
        chk("flush_commit", commit_valid, 0);
        cyc();
        flush = 0; rs1_rob_entry = 3'd2; rs2_rob_entry = 3'd3; #1;
        chk("flush_tail", alloc_rob_id, 0);
        chk("flush_ready", alloc_ready, 1);
        chk("flush_s1_valid", rob_s1_valid, 0);
        chk("flush_s2_valid", rob_s2_valid, 0);

        // Reset mid-operation overrides active writebacks.
        alloc_n(5);
        alu_wb_enable = 1; alu_wb_rob_id = 3'd1; alu_wb_data = 32'h77;
        mem_wb_enable = 1; mem_wb_rob_id = 3'd2; mem_wb_data = 32'h88;
        rst = 1; cyc();
        rst = 0; alu_wb_enable = 0; mem_wb_enable = 0;
        rs1_rob_entry = 3'd1; rs2_rob_entry = 3'd2; #1;
        chk("mid_rst_ready", alloc_ready, 1);
        chk("mid_rst_tail", alloc_rob_id, 0);
        chk("mid_rst_commit", commit_valid, 0);
        chk("mid_rst_s1_valid", rob_s1_valid, 0);
        chk("mid_rst_s2_valid", rob_s2_valid, 0);
        chk("mid_rst_s1_data", rob_s1_data, 0);
        chk("mid_rst_s2_data", rob_s2_data, 0);
        alu_wb_enable = 1; alu_wb_rob_id = 3'd1; alu_wb_data = 32'h55; cyc();
        alu_wb_enable = 0; #1;
        chk("stale_wb_ignored", rob_s1_valid, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            flush         = ($urandom_range(0, 39) == 0);
            alloc_valid   = ($urandom_range(0, 2) != 0);
            alloc_rd      = 5'($urandom);
            alloc_we      = 1'($urandom);
            alu_wb_enable = 1'($urandom);
            alu_wb_rob_id = pick_id();
            alu_wb_data   = $urandom;
            mem_wb_enable = 1'($urandom);
            mem_wb_rob_id = pick_id();
            mem_wb_data   = $urandom;
            mul_wb_enable = 1'($urandom);
            mul_wb_rob_id = pick_id();
            mul_wb_data   = $urandom;
            rs1_rob_entry = pick_id();
            rs2_rob_entry = pick_id();
            cyc();
        end
        idle();
        rst = 0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
